// File: rtl/switch_sched_rr.sv
`default_nettype none
// ============================================================================
//  Module      : switch_sched_rr
//  Description : N-port crossbar scheduler with a round-robin arbiter per output;
//                multi-word packets hold their crossbar path until the last word.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_sched_rr #(
    parameter int NPORTS = 4,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 3,
    localparam int DEST_W = $clog2(NPORTS + 1),
    localparam int SEL_W  = $clog2(NPORTS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS*DATA_W-1:0] data,
    input  logic [NPORTS-1:0]        empty,
    output logic [NPORTS-1:0]        rdreq,
    output logic [NPORTS*SEL_W-1:0]  sel,
    output logic [NPORTS-1:0]        en
);

    localparam logic [1:0]        c_IDLE     = 2'd0;
    localparam logic [1:0]        c_FWD      = 2'd1;
    localparam logic [1:0]        c_DROP     = 2'd2;
    localparam logic [LEN_W:0]    c_CNT_ONE  = (LEN_W+1)'(1);
    localparam logic [DEST_W-1:0] c_DEST_MAX = DEST_W'(NPORTS);
    localparam logic [SEL_W-1:0]  c_SEL_LAST = SEL_W'(NPORTS - 1);

    logic [1:0]        r_in_state   [NPORTS];
    logic [1:0]        w_in_state_nxt [NPORTS];
    logic [LEN_W:0]    r_cnt        [NPORTS];
    logic [LEN_W:0]    w_cnt_nxt    [NPORTS];
    logic [NPORTS-1:0] r_out_busy;
    logic [NPORTS-1:0] w_out_busy_nxt;
    logic [SEL_W-1:0]  r_out_src    [NPORTS];
    logic [SEL_W-1:0]  w_out_src_nxt [NPORTS];
    logic [SEL_W-1:0]  r_ptr        [NPORTS];
    logic [SEL_W-1:0]  w_ptr_nxt    [NPORTS];

    logic [DEST_W-1:0] w_dest       [NPORTS];
    logic [LEN_W-1:0]  w_len        [NPORTS];
    logic [LEN_W:0]    w_len_eff    [NPORTS];
    logic [NPORTS-1:0] w_valid;
    logic [NPORTS-1:0] w_idle_rdy;
    logic [NPORTS-1:0] w_pop;
    logic [NPORTS-1:0] w_last;
    logic [NPORTS-1:0] w_req        [NPORTS];
    logic [NPORTS-1:0] w_gnt_vld;
    logic [SEL_W-1:0]  w_gnt_idx    [NPORTS];
    logic [SEL_W-1:0]  w_scan_idx;
    logic              w_unused_data;

    // Payload bits above the header fields are never decoded here.
    assign w_unused_data = ^data;

    function automatic logic [SEL_W-1:0] f_wrap(input int v);
        return (v >= NPORTS) ? SEL_W'(v - NPORTS) : SEL_W'(v);
    endfunction

    generate
        for (genvar i = 0; i < NPORTS; i++) begin : g_in
            assign w_dest[i]     = data[i*DATA_W +: DEST_W];
            assign w_len[i]      = data[i*DATA_W + DEST_W +: LEN_W];
            assign w_len_eff[i]  = (w_len[i] == '0) ? c_CNT_ONE : {1'b0, w_len[i]};
            assign w_valid[i]    = (w_dest[i] != '0) && (w_dest[i] <= c_DEST_MAX);
            assign w_idle_rdy[i] = (r_in_state[i] == c_IDLE) && !empty[i];
            // Outputs are gated by reset so nothing pulses in the cycle reset rises.
            assign w_pop[i]      = (r_in_state[i] != c_IDLE) && !empty[i] && !reset;
            assign w_last[i]     = w_pop[i] && (r_cnt[i] == c_CNT_ONE);
            assign rdreq[i]      = w_pop[i];
        end

        for (genvar j = 0; j < NPORTS; j++) begin : g_out
            assign en[j] = r_out_busy[j] && !empty[r_out_src[j]] && !reset;
            assign sel[j*SEL_W +: SEL_W] = reset ? '0 : r_out_src[j];
        end
    endgenerate

    always_comb begin
        w_scan_idx = '0;
        for (int j = 0; j < NPORTS; j++) begin
            w_gnt_vld[j] = 1'b0;
            w_gnt_idx[j] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                w_req[j][i] = w_idle_rdy[i] && w_valid[i] && (w_dest[i] == DEST_W'(j + 1));
            end
            // Scan starting at the pointer; first hit wins.
            for (int k = 0; k < NPORTS; k++) begin
                w_scan_idx = f_wrap(int'(r_ptr[j]) + k);
                if (!r_out_busy[j] && !w_gnt_vld[j] && w_req[j][w_scan_idx]) begin
                    w_gnt_vld[j] = 1'b1;
                    w_gnt_idx[j] = w_scan_idx;
                end
            end
        end
    end

    always_comb begin
        w_in_state_nxt = r_in_state;
        w_cnt_nxt      = r_cnt;
        w_out_busy_nxt = r_out_busy;
        w_out_src_nxt  = r_out_src;
        w_ptr_nxt      = r_ptr;
        for (int i = 0; i < NPORTS; i++) begin
            if (w_pop[i]) begin
                w_cnt_nxt[i] = r_cnt[i] - c_CNT_ONE;
                if (w_last[i]) w_in_state_nxt[i] = c_IDLE;
            end else if (w_idle_rdy[i] && !w_valid[i]) begin
                w_in_state_nxt[i] = c_DROP;
                w_cnt_nxt[i]      = w_len_eff[i];
            end
        end
        for (int j = 0; j < NPORTS; j++) begin
            if (r_out_busy[j] && w_last[r_out_src[j]]) begin
                w_out_busy_nxt[j] = 1'b0;
                w_out_src_nxt[j]  = '0;
            end
            // Grants only go to free outputs and idle inputs, so they never collide
            // with the release/pop updates above.
            if (w_gnt_vld[j]) begin
                w_out_busy_nxt[j]             = 1'b1;
                w_out_src_nxt[j]              = w_gnt_idx[j];
                w_ptr_nxt[j]                  = (w_gnt_idx[j] == c_SEL_LAST) ? '0 : w_gnt_idx[j] + 1'b1;
                w_in_state_nxt[w_gnt_idx[j]] = c_FWD;
                w_cnt_nxt[w_gnt_idx[j]]      = w_len_eff[w_gnt_idx[j]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_busy <= '0;
            for (int i = 0; i < NPORTS; i++) begin
                r_in_state[i] <= c_IDLE;
                r_cnt[i]      <= '0;
                r_out_src[i]  <= '0;
                r_ptr[i]      <= '0;
            end
        end else begin
            r_in_state <= w_in_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_out_busy <= w_out_busy_nxt;
            r_out_src  <= w_out_src_nxt;
            r_ptr      <= w_ptr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_switch_sched_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_sched_rr
//  Description : Self-checking bench for switch_sched_rr (4 ports) with FIFO
//                models and a per-output expected-word scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_sched_rr;

    logic        clk;
    logic        reset;
    logic [31:0] data;
    logic [3:0]  empty;
    logic [3:0]  rdreq;
    logic [7:0]  sel;
    logic [3:0]  en;

    logic [7:0]  fifo     [4][$];
    logic [15:0] exp_q    [4][$];
    int          exp_drop [4];
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  s_rdreq;
    logic [3:0]  s_en;
    logic [7:0]  s_sel;

    switch_sched_rr #(.NPORTS(4), .DATA_W(8), .LEN_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .data  (data),
        .empty (empty),
        .rdreq (rdreq),
        .sel   (sel),
        .en    (en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hdr(input int d, input int l);
        return {2'b00, 3'(l), 3'(d)};
    endfunction

    task automatic upd();
        for (int i = 0; i < 4; i++) begin
            empty[i]       = (fifo[i].size() == 0);
            data[i*8 +: 8] = (fifo[i].size() == 0) ? 8'h00 : fifo[i][0];
        end
    endtask

    task automatic expect_word(input int j, input int i, input logic [7:0] w);
        exp_q[j].push_back({6'b0, 2'(i), w});
    endtask

    // Pushes a whole packet and records where its words must appear.
    task automatic send(input int i, input int d, input int l);
        int n;
        logic [7:0] w;
        n = (l == 0) ? 1 : l;
        for (int k = 0; k < n; k++) begin
            w = (k == 0) ? hdr(d, l) : 8'(8'h40 + i*16 + k);
            fifo[i].push_back(w);
            if (d >= 1 && d <= 4) expect_word(d - 1, i, w);
            else exp_drop[i]++;
        end
        upd();
    endtask

    // Sample at the falling edge, then apply the pops at the next rising edge.
    task automatic cyc();
        logic [1:0] src;
        logic [3:0] fwd_src;
        @(negedge clk);
        s_rdreq = rdreq;
        s_en    = en;
        s_sel   = sel;
        fwd_src = 4'b0;
        for (int j = 0; j < 4; j++) begin
            if (s_en[j]) begin
                src = s_sel[j*2 +: 2];
                fwd_src[src] = 1'b1;
                chk("en_pop", 32'(s_rdreq[src]), 32'd1);
                if (exp_q[j].size() == 0) chk("out_unexp", 32'(s_en[j]), 32'd0);
                else chk("out_word", {16'b0, 6'b0, src, data[src*8 +: 8]}, {16'b0, exp_q[j].pop_front()});
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (s_rdreq[i] && !fwd_src[i]) begin
                if (exp_drop[i] > 0) exp_drop[i]--;
                else chk("pop_unexp", 32'(s_rdreq[i]), 32'd0);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (s_rdreq[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
        upd();
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) begin
            fifo[i].delete();
            exp_q[i].delete();
            exp_drop[i] = 0;
        end
        upd();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int j = 0; j < 4; j++) begin
            chk({tag, "_left"}, 32'(exp_q[j].size()), 32'd0);
            chk({tag, "_drop"}, 32'(exp_drop[j]), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1;
        flush();
        cyc();
        chk("rst_rdreq", 32'(s_rdreq), 32'd0);
        chk("rst_en", 32'(s_en), 32'd0);
        chk("rst_sel", 32'(s_sel), 32'd0);
        cyc();
        reset = 1'b0;
        cyc();
        chk("idle_en", 32'(s_en), 32'd0);

        // Single 3-word packet: in0 -> out1 with exact timing.
        send(0, 2, 3);
        cyc();
        chk("t1_arb_rdreq", 32'(s_rdreq), 32'd0);
        chk("t1_arb_en", 32'(s_en), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t1_rdreq", 32'(s_rdreq), 32'b0001);
            chk("t1_en", 32'(s_en), 32'b0010);
            chk("t1_sel1", 32'(s_sel[3:2]), 32'd0);
        end
        cyc();
        chk("t1_end_rdreq", 32'(s_rdreq), 32'd0);
        chk("t1_end_en", 32'(s_en), 32'd0);
        drain("t1");

        // Round-robin on out0 from in0..in2, single-word packets.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 3; i++) fifo[i].push_back(hdr(1, 1));
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 3; i++) expect_word(0, i, hdr(1, 1));
        upd();
        for (int k = 0; k < 16; k++) cyc();
        drain("t2");

        // Discards on in3: dest 0 and dest 7.
        do_reset();
        send(3, 0, 2);
        send(3, 7, 2);
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("t3_en", 32'(s_en), 32'd0);
        end
        drain("t3");

        // Mid-packet stall: in0 -> out2, FIFO runs dry after word 2.
        do_reset();
        fifo[0].push_back(hdr(3, 4));
        fifo[0].push_back(8'h51);
        expect_word(2, 0, hdr(3, 4));
        expect_word(2, 0, 8'h51);
        upd();
        cyc();
        cyc();
        cyc();
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("t4_stall_rdreq", 32'(s_rdreq), 32'd0);
            chk("t4_stall_en", 32'(s_en), 32'd0);
            chk("t4_stall_sel2", 32'(s_sel[5:4]), 32'd0);
        end
        fifo[0].push_back(8'h52);
        fifo[0].push_back(8'h53);
        expect_word(2, 0, 8'h52);
        expect_word(2, 0, 8'h53);
        upd();
        cyc();
        chk("t4_resume_en", 32'(s_en), 32'b0100);
        cyc();
        cyc();
        chk("t4_release_en", 32'(s_en), 32'd0);
        drain("t4");

        // Four disjoint paths in parallel.
        do_reset();
        send(0, 2, 2);
        send(1, 3, 2);
        send(2, 4, 2);
        send(3, 1, 2);
        cyc();
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("t5_en", 32'(s_en), 32'hf);
            chk("t5_sel", 32'(s_sel), 32'b10_01_00_11);
        end
        cyc();
        chk("t5_end_en", 32'(s_en), 32'd0);
        drain("t5");

        // Reset in the middle of a 4-word packet, then pointer must be back at 0.
        do_reset();
        send(0, 2, 4);
        cyc();
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        chk("t6_rst_rdreq", 32'(s_rdreq), 32'd0);
        chk("t6_rst_en", 32'(s_en), 32'd0);
        chk("t6_rst_sel", 32'(s_sel), 32'd0);
        flush();
        cyc();
        chk("t6_rst2_en", 32'(s_en), 32'd0);
        reset = 1'b0;
        fifo[1].push_back(hdr(2, 1));
        fifo[0].push_back(hdr(2, 1));
        expect_word(1, 0, hdr(2, 1));
        expect_word(1, 1, hdr(2, 1));
        upd();
        for (int k = 0; k < 6; k++) cyc();
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
